// File: rtl/riscv_icache_param.sv
// riscv_icache_param
// Direct-mapped instruction cache that sits between the IF stage and
// instruction memory. Each line holds a valid bit, a tag and WORDS_PER_LINE
// 32-bit words. A miss stalls IF and refills the whole line one word at a
// time over a req/ack handshake. The refill then returns the requested word.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   cpu_req     fetch request from IF
//   cpu_addr    fetch byte address; bits [1:0] are ignored
//   flush       invalidate every line
//   cpu_instr   fetched instruction (registered)
//   cpu_valid   cpu_instr is valid this cycle (registered)
//   cpu_stall   IF must hold PC/cpu_addr (combinational)
//   mem_req     refill word request (registered)
//   mem_addr    word-aligned refill address (registered)
//   mem_ack     memory accepts the current word; mem_rdata is valid
//   mem_rdata   refill data
//   hit_count   saturating hit counter
//   miss_count  saturating miss counter
module riscv_icache_param #(
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  input  logic             flush,
  output logic [31:0]      cpu_instr,
  output logic             cpu_valid,
  output logic             cpu_stall,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int OFF   = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 30 - OFF - IDX;
  // The word field is empty for one-word lines; its register is kept 1 bit wide.
  localparam int OFF_W = (OFF > 0) ? OFF : 1;
  localparam int DEPTH = LINES * WORDS_PER_LINE;
  localparam int DA_W  = $clog2(DEPTH);
  localparam logic [31:0] LINE_MASK = ~(32'(WORDS_PER_LINE * 4) - 32'd1);
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [LINES-1:0]       r_valid;
  logic [TAG_W-1:0]       r_tag [LINES];
  logic [31:0]            r_data [DEPTH];
  logic [31:0]            r_addr;
  logic [OFF_W-1:0]       r_cnt;
  logic                   r_flush_pend;
  logic                   w_hit;
  logic                   w_miss;
  logic                   w_last;
  logic                   w_stall;
  logic [IDX-1:0]         w_cpu_idx;
  logic [IDX-1:0]         w_fill_idx;
  logic [31:0]            w_hit_data;
  logic [31:0]            w_resp_data;

  function automatic logic [OFF_W-1:0] f_word(input logic [31:0] a);
    return OFF_W'(a[31:2] & 30'(WORDS_PER_LINE - 1));
  endfunction

  function automatic logic [IDX-1:0] f_index(input logic [31:0] a);
    return IDX'(a[31:2] >> OFF);
  endfunction

  function automatic logic [TAG_W-1:0] f_tag(input logic [31:0] a);
    return TAG_W'(a[31:2] >> (OFF + IDX));
  endfunction

  // Flat data-array address: line index in the upper bits, word below it.
  function automatic logic [DA_W-1:0] f_daddr(input logic [IDX-1:0] idx,
                                              input logic [OFF_W-1:0] wrd);
    return (DA_W'(idx) << OFF) | DA_W'(wrd);
  endfunction

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  assign w_cpu_idx   = f_index(cpu_addr);
  assign w_fill_idx  = f_index(r_addr);
  assign w_hit_data  = r_data[f_daddr(w_cpu_idx, f_word(cpu_addr))];
  assign w_resp_data = r_data[f_daddr(w_fill_idx, f_word(r_addr))];
  // A flush in the same cycle turns a would-be hit into a miss.
  assign w_hit  = cpu_req & ~flush & r_valid[w_cpu_idx] &
                  (r_tag[w_cpu_idx] == f_tag(cpu_addr));
  assign w_miss = cpu_req & ~w_hit;
  assign w_last = (r_cnt == LAST_WORD);
  assign cpu_stall = w_stall;

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and stall decode
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_state_next = S_REFILL;
          w_stall      = 1'b1;
        end else begin
          w_state_next = S_IDLE;
          w_stall      = 1'b0;
        end
      end
      S_REFILL: begin
        w_stall = 1'b1;
        if (mem_ack && w_last) begin
          w_state_next = S_RESP;
        end else begin
          w_state_next = S_REFILL;
        end
      end
      S_RESP: begin
        w_stall      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_stall      = 1'b0;
      end
    endcase
  end

  // Control registers, valid bits, registered outputs and counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid      <= {LINES{1'b0}};
      r_addr       <= 32'd0;
      r_cnt        <= {OFF_W{1'b0}};
      r_flush_pend <= 1'b0;
      cpu_instr    <= 32'd0;
      cpu_valid    <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= 32'd0;
      hit_count    <= {CNT_W{1'b0}};
      miss_count   <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_valid <= {LINES{1'b0}};
          end
          if (w_hit) begin
            cpu_instr <= w_hit_data;
            cpu_valid <= 1'b1;
            hit_count <= f_sat_inc(hit_count);
          end else if (w_miss) begin
            cpu_valid  <= 1'b0;
            r_addr     <= cpu_addr;
            r_cnt      <= {OFF_W{1'b0}};
            mem_req    <= 1'b1;
            mem_addr   <= cpu_addr & LINE_MASK;
            miss_count <= f_sat_inc(miss_count);
          end else begin
            cpu_valid <= 1'b0;
          end
        end
        S_REFILL: begin
          cpu_valid <= 1'b0;
          if (flush) begin
            r_flush_pend <= 1'b1;
          end
          if (mem_ack) begin
            r_cnt <= r_cnt + OFF_W'(1);
            if (w_last) begin
              r_valid[w_fill_idx] <= 1'b1;
              mem_req             <= 1'b0;
            end else begin
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        S_RESP: begin
          cpu_instr <= w_resp_data;
          cpu_valid <= 1'b1;
          // Deferred flush also drops the line that was just filled.
          if (r_flush_pend || flush) begin
            r_valid      <= {LINES{1'b0}};
            r_flush_pend <= 1'b0;
          end
        end
        default: begin
          cpu_valid <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays; their contents are qualified by r_valid, so no reset
  always_ff @(posedge clock) begin
    if (r_state == S_REFILL && mem_ack) begin
      r_data[f_daddr(w_fill_idx, r_cnt)] <= mem_rdata;
      if (w_last) begin
        r_tag[w_fill_idx] <= f_tag(r_addr);
      end
    end
  end

endmodule

// File: tb/tb_riscv_icache_param.sv
module tb_riscv_icache_param;

  localparam int LINES = 8;
  localparam int WPL   = 4;
  localparam int CNT_W = 16;
  localparam int SAT_W = 3;
  localparam int SAT_MAX = 7;

  logic             clock;
  logic             reset;
  logic             cpu_req;
  logic [31:0]      cpu_addr;
  logic             flush;
  logic [31:0]      cpu_instr;
  logic             cpu_valid;
  logic             cpu_stall;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_ack;
  logic [31:0]      mem_rdata;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  // Twin with narrow counters to exercise saturation.
  logic [31:0]      s_instr;
  logic             s_valid;
  logic             s_stall;
  logic             s_mem_req;
  logic [31:0]      s_mem_addr;
  logic [SAT_W-1:0] s_hit_count;
  logic [SAT_W-1:0] s_miss_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: line address held per index, plus transaction counts.
  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];
  int          m_hits = 0;
  int          m_miss = 0;

  riscv_icache_param #(.LINES(LINES), .WORDS_PER_LINE(WPL), .CNT_W(CNT_W)) u_dut (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .flush(flush), .cpu_instr(cpu_instr), .cpu_valid(cpu_valid),
    .cpu_stall(cpu_stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  riscv_icache_param #(.LINES(LINES), .WORDS_PER_LINE(WPL), .CNT_W(SAT_W)) u_sat (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .flush(flush), .cpu_instr(s_instr), .cpu_valid(s_valid),
    .cpu_stall(s_stall), .mem_req(s_mem_req), .mem_addr(s_mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_count(s_hit_count),
    .miss_count(s_miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory contents: 0x10 -> 0xA0, 0x14 -> 0xA1, ...
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_009C + {2'b00, a[31:2]};
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 4) & 32'd7);
  endfunction

  function automatic logic [31:0] sat(input int v);
    return (v > SAT_MAX) ? 32'(SAT_MAX) : 32'(v);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_counters();
    check_val("hit_count", 32'(hit_count), 32'(m_hits));
    check_val("miss_count", 32'(miss_count), 32'(m_miss));
    check_val("hit_sat", 32'(s_hit_count), sat(m_hits));
    check_val("miss_sat", 32'(s_miss_count), sat(m_miss));
  endtask

  // One fetch, entered and left at a falling edge. ack_mode: 0 = ack every
  // cycle, 1 = every 3rd cycle, 2 = random. fl_word >= 0 pulses flush while
  // that refill word is being requested.
  task automatic fetch(input logic [31:0] a, input int ack_mode,
                       input bit fl_entry, input int fl_word,
                       output int refill_cycles);
    bit hit_exp;
    bit fl_done;
    int w;
    int stall_n;
    int k;
    int ix;
    logic [31:0] base;
    ix = idx_of(a);
    cpu_req = 1'b1;
    cpu_addr = a;
    flush = fl_entry;
    mem_ack = 1'b0;
    #1;
    hit_exp = !fl_entry && m_valid[ix] && (m_line[ix] == (a >> 4));
    check_val("stall_on_req", 32'(cpu_stall), 32'(!hit_exp));
    check_val("twin_stall_on_req", 32'(s_stall), 32'(!hit_exp));
    refill_cycles = 0;
    if (fl_entry) model_clear();
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    if (hit_exp) begin
      m_hits++;
      check_val("hit_valid", 32'(cpu_valid), 32'd1);
      check_val("hit_instr", cpu_instr, mem_word(a));
      check_val("twin_hit_instr", s_instr, mem_word(a));
    end else begin
      m_miss++;
      base = a & ~32'h0000_000F;
      w = 0;
      stall_n = 1;
      fl_done = 1'b0;
      k = 0;
      while (!cpu_valid && k < 200) begin
        check_val("stall_busy", 32'(cpu_stall), 32'd1);
        stall_n++;
        if (mem_req) begin
          check_val("mem_addr", mem_addr, base + 32'(4 * w));
          check_val("twin_mem_addr", s_mem_addr, base + 32'(4 * w));
          refill_cycles++;
          case (ack_mode)
            0: mem_ack = 1'b1;
            1: mem_ack = ((refill_cycles % 3) == 0);
            default: mem_ack = 1'($urandom_range(0, 1));
          endcase
          if (fl_word == w && !fl_done) begin
            flush = 1'b1;
            fl_done = 1'b1;
          end else begin
            flush = 1'b0;
          end
          if (mem_ack) w++;
        end else begin
          check_val("resp_words", 32'(w), 32'(WPL));
          mem_ack = 1'b0;
          flush = 1'b0;
        end
        cpu_addr = $urandom;
        @(posedge clock);
        @(negedge clock);
        k++;
      end
      mem_ack = 1'b0;
      flush = 1'b0;
      check_val("refill_done", 32'(cpu_valid), 32'd1);
      check_val("miss_instr", cpu_instr, mem_word(a));
      check_val("twin_miss_instr", s_instr, mem_word(a));
      check_val("stall_cycles", 32'(stall_n), 32'(refill_cycles + 2));
      m_valid[ix] = 1'b1;
      m_line[ix] = a >> 4;
      if (fl_done) model_clear();
    end
    check_counters();
  endtask

  // One cycle without a request, optionally flushing.
  task automatic idle(input bit fl);
    cpu_req = 1'b0;
    flush = fl;
    mem_ack = 1'b0;
    #1;
    check_val("idle_stall", 32'(cpu_stall), 32'd0);
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    check_val("idle_valid", 32'(cpu_valid), 32'd0);
    if (fl) model_clear();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_instr"}, cpu_instr, 32'd0);
    check_val({tag, "_valid"}, 32'(cpu_valid), 32'd0);
    check_val({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check_val({tag, "_mem_addr"}, mem_addr, 32'd0);
    check_val({tag, "_hits"}, 32'(hit_count), 32'd0);
    check_val({tag, "_misses"}, 32'(miss_count), 32'd0);
    check_val({tag, "_twin_mem_req"}, 32'(s_mem_req), 32'd0);
    check_val({tag, "_twin_valid"}, 32'(s_valid), 32'd0);
  endtask

  int rc;
  int miss_before;
  logic [31:0] ra;

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0;
    cpu_addr = 32'd0;
    flush = 1'b0;
    mem_ack = 1'b0;
    model_clear();
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("rst");
    check_val("rst_stall", 32'(cpu_stall), 32'd0);

    // Cold miss: four words at one per cycle.
    fetch(32'h0000_0010, 0, 1'b0, -1, rc);
    check_val("cold_refill_len", 32'(rc), 32'd4);

    // Spatial hits, back to back.
    fetch(32'h0000_0014, 0, 1'b0, -1, rc);
    fetch(32'h0000_0018, 0, 1'b0, -1, rc);
    fetch(32'h0000_001C, 0, 1'b0, -1, rc);
    check_val("spatial_hits", 32'(hit_count), 32'd3);
    idle(1'b0);

    // Conflict on index 0.
    miss_before = m_miss;
    fetch(32'h0000_0000, 0, 1'b0, -1, rc);
    fetch(32'h0000_0080, 0, 1'b0, -1, rc);
    fetch(32'h0000_0000, 0, 1'b0, -1, rc);
    check_val("conflict_misses", 32'(int'(miss_count) - miss_before), 32'd3);

    // Slow memory: ack every third cycle.
    fetch(32'h0000_0248, 1, 1'b0, -1, rc);
    check_val("slow_refill_len", 32'(rc), 32'd12);

    // Flush while the second word is requested; the line must not survive.
    fetch(32'h0000_0304, 0, 1'b0, 1, rc);
    miss_before = m_miss;
    fetch(32'h0000_0308, 0, 1'b0, -1, rc);
    check_val("post_flush_miss", 32'(m_miss - miss_before), 32'd1);
    check_val("post_flush_refill", 32'(rc), 32'd4);

    // Flush in IDLE, then a same-cycle flush with a request to a valid line.
    idle(1'b1);
    fetch(32'h0000_0308, 0, 1'b0, -1, rc);
    check_val("idle_flush_miss", 32'(rc), 32'd4);
    fetch(32'h0000_030C, 0, 1'b1, -1, rc);
    check_val("flush_req_miss", 32'(rc), 32'd4);

    // Asynchronous reset in the middle of a refill.
    cpu_req = 1'b1;
    cpu_addr = 32'h0000_0450;
    @(posedge clock);
    @(negedge clock);
    check_val("mid_mem_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    @(posedge clock);
    @(negedge clock);
    mem_ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    cpu_req = 1'b0;
    #1;
    check_val("async_rst_stall", 32'(cpu_stall), 32'd0);
    @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    model_clear();
    m_hits = 0;
    m_miss = 0;
    fetch(32'h0000_0450, 0, 1'b0, -1, rc);
    check_val("rerequest_miss", 32'(rc), 32'd4);

    // Randomised traffic over a small address pool to mix hits and conflicts.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle(1'($urandom_range(0, 3) == 0));
      end else begin
        ra = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        fetch(ra, $urandom_range(0, 2), 1'($urandom_range(0, 15) == 0),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1, rc);
      end
    end
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_icache_param.md
Name: riscv_icache_param

Overview:
- Parametrised direct-mapped instruction cache between the PC/IF stage and instruction memory of the RISC-V pipeline.
- Generalises the fixed 4-line, 1-word-per-line fetch cache to configurable line count and multi-word lines.
- Adds a burst refill FSM with a req/ack memory handshake, a pipeline stall output, a whole-cache flush, and hit/miss counters.

Parameters:
- LINES, 8, number of cache lines; power of 2, minimum 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, minimum 1.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  fetch request from IF.
- cpu_addr  in  32  byte address of the fetch; bits [1:0] are ignored.
- flush  in  1  invalidate all lines.
- cpu_instr  out  32  fetched instruction.
- cpu_valid  out  1  cpu_instr is valid this cycle.
- cpu_stall  out  1  IF must hold PC and cpu_addr.
- mem_req  out  1  refill word request.
- mem_addr  out  32  word-aligned refill address.
- mem_ack  in  1  mem_rdata valid; the current word is accepted.
- mem_rdata  in  32  refill data.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Address fields:
  - OFF = log2(WORDS_PER_LINE); IDX = log2(LINES).
  - word = cpu_addr[2+OFF-1:2]; index = cpu_addr[2+OFF+IDX-1:2+OFF]; tag = the remaining upper bits.
  - When WORDS_PER_LINE = 1, the word field is empty.
- Storage per line: valid bit, tag, and WORDS_PER_LINE data words.
- FSM states: IDLE, REFILL, RESP.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; all valid bits are cleared; the refill word counter is cleared; the pending-flush latch is cleared.
  - Outputs: cpu_instr=0, cpu_valid=0, mem_req=0, mem_addr=0, hit_count=0, miss_count=0.
  - Reset asserted mid-refill abandons the refill. No line is left valid.
- IDLE:
  - hit = cpu_req & valid[index] & tag match.
  - On a hit: next edge registers cpu_instr = data word, cpu_valid=1, hit_count+1. Hit latency is 1 cycle. Back-to-back hits give one instruction per cycle.
  - On a miss (cpu_req & !hit): cpu_stall=1 combinationally in the same cycle. Next edge: latch the request address, set word counter=0, mem_req=1, mem_addr = {tag,index,OFF'b0,2'b00}, miss_count+1, go to REFILL.
  - cpu_req=0: cpu_valid=0 on the next edge; no state change.
- REFILL:
  - cpu_stall=1 and mem_req=1 throughout.
  - mem_addr = line base + 4*counter. It holds stable until mem_ack.
  - On mem_ack: write mem_rdata to data[index][counter] and increment counter.
  - On the ack of the last word: set valid and tag, drop mem_req on the next edge, go to RESP.
  - mem_ack may be held high continuously, giving one word per cycle.
  - cpu_addr changes during REFILL are ignored; the latched address is used.
- RESP:
  - cpu_stall=1 for this single cycle.
  - Next edge: cpu_instr = data[index][latched word], cpu_valid=1, go to IDLE.
  - The response is not counted as a hit.
- cpu_stall = (state != IDLE) | (state == IDLE & cpu_req & !hit).
- cpu_valid is low in every cycle not listed above.
- Flush:
  - In IDLE, flush clears all valid bits on the next edge. A same-cycle cpu_req is treated as a miss.
  - In REFILL or RESP, flush sets the pending latch. The refill and response complete normally. All valid bits, including the just-filled line, are cleared on the edge that returns to IDLE.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Conflict: two addresses with the same index and different tags evict each other. No replacement policy beyond direct mapping.

Test Plan:
- Cold miss, defaults: reset, cpu_req with addr 0x00000010, mem_ack high on every cycle returning 0xA0+n per word. Required:
  - mem_addr sequence is 0x10, 0x14, 0x18, 0x1C.
  - cpu_stall is high for 6 cycles.
  - cpu_valid fires with cpu_instr = 0xA0.
  - miss_count = 1.
- Spatial hit: after the first test, requests 0x14, 0x18, 0x1C on consecutive cycles. Required: cpu_instr = 0xA1, 0xA2, 0xA3 with 1-cycle latency, no stall, hit_count = 3.
- Conflict: fill 0x00, then 0x80 (same index 0, tag differs), then 0x00. Required: three misses, miss_count = 3, mem_addr 0x00, then 0x80, then 0x00.
- Slow memory: mem_ack asserted every 3rd cycle. Required: mem_addr holds per word, mem_req stays high through the refill, and the correct word is returned after 12 refill cycles.
- Flush during REFILL: flush pulses at the second word. Required: the refill completes, cpu_valid is delivered, and the next request to the same line misses.
- Async reset mid-refill (reset low between clock edges): outputs go to 0 immediately, the FSM goes to IDLE, and a re-request of the same address misses.
